// File: rtl/lisa_qspi_arb.sv
`default_nettype none
// ============================================================================
// Module   : lisa_qspi_arb
// Purpose  : Shares one QSPI pin set (sclk, dq[3:0]) between the SPI flash
//            (CE0) and the SPI PSRAM (CE1). Two requesters (port 0 =
//            instruction fetch, port 1 = data load/store) are arbitrated
//            round-robin. Each grant runs one quad-mode single-byte
//            transaction: command, 24-bit address, dummy cycles (reads only),
//            then one data byte. Both devices are assumed to be in QPI mode.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req/we/sel/addr/wdata{0,1} - per-port request, direction,
//                                  target (0 flash, 1 PSRAM), address, data
//            ack0/ack1           - one-cycle completion pulse per port
//            rdata               - last read byte (shared by both ports)
//            busy                - transaction in progress
//            ce0_n/ce1_n, sclk, dq_out, dq_oe, dq_in - QSPI pad interface
// Revision : 1.0 - initial release
// ============================================================================
module lisa_qspi_arb #(
  parameter int         DUMMY_FLASH = 6,
  parameter int         DUMMY_PSRAM = 6,
  parameter logic [7:0] CMD_RD      = 8'hEB,
  parameter logic [7:0] CMD_WR      = 8'h38
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic        sel0,
  input  logic [23:0] addr0,
  input  logic [7:0]  wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic        sel1,
  input  logic [23:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        ce0_n,
  output logic        ce1_n,
  output logic        sclk,
  output logic [3:0]  dq_out,
  output logic [3:0]  dq_oe,
  input  logic [3:0]  dq_in
);

  // --------------------------------------------------------------------------
  // State encoding and phase lengths (counted in clk cycles, last index)
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_cmd   = 3'd1;
  localparam logic [2:0] c_addr  = 3'd2;
  localparam logic [2:0] c_dummy = 3'd3;
  localparam logic [2:0] c_data  = 3'd4;
  localparam logic [2:0] c_done  = 3'd5;

  // Every nibble slot is two clk: phase A (sclk low), phase B (sclk high).
  localparam logic [7:0] c_cmd_last   = 8'd3;   // 2 nibbles
  localparam logic [7:0] c_addr_last  = 8'd11;  // 6 nibbles
  localparam logic [7:0] c_data_last  = 8'd3;   // 2 nibbles
  localparam logic [7:0] c_dflash_last = 8'(2 * DUMMY_FLASH - 1);
  localparam logic [7:0] c_dpsram_last = 8'(2 * DUMMY_PSRAM - 1);
  localparam bit         c_skip_dflash = (DUMMY_FLASH == 0);
  localparam bit         c_skip_dpsram = (DUMMY_PSRAM == 0);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;            // clk cycles spent in current phase
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;            // port owning the current transaction
  logic        we_q, we_d;
  logic        sel_q, sel_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  rd_hi_q, rd_hi_d;        // high nibble held until the low one arrives
  logic [7:0]  rdata_q, rdata_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_any_req;
  logic        w_pick;                  // port selected by the arbiter
  logic        w_we, w_sel;
  logic [23:0] w_addr;
  logic [7:0]  w_wdata;
  logic [7:0]  w_cmd;
  logic [7:0]  w_dummy_last;
  logic        w_dummy_skip;
  logic        w_active;                // a chip enable is asserted
  logic [2:0]  w_nib_idx;               // nibble slot within the phase

  assign w_any_req = req0 | req1;
  // With both requesting, the port that did not win last time goes next.
  assign w_pick    = (req0 & req1) ? ~last_grant_q : req1;
  assign w_we      = w_pick ? we1    : we0;
  assign w_sel     = w_pick ? sel1   : sel0;
  assign w_addr    = w_pick ? addr1  : addr0;
  assign w_wdata   = w_pick ? wdata1 : wdata0;

  assign w_cmd        = we_q  ? CMD_WR        : CMD_RD;
  assign w_dummy_last = sel_q ? c_dpsram_last : c_dflash_last;
  assign w_dummy_skip = sel_q ? c_skip_dpsram : c_skip_dflash;
  assign w_nib_idx    = cnt_q[3:1];

  assign w_active = (state_q == c_cmd)   || (state_q == c_addr) ||
                    (state_q == c_dummy) || (state_q == c_data);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_idle;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;             // port 0 wins the first contention
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 1'b0;
      addr_q       <= 24'd0;
      wdata_q      <= 8'd0;
      rd_hi_q      <= 4'd0;
      rdata_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_hi_q      <= rd_hi_d;
      rdata_q      <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 8'd1;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_hi_d      = rd_hi_q;
    rdata_d      = rdata_q;

    case (state_q)
      c_idle: begin
        cnt_d = 8'd0;
        if (w_any_req) begin
          // Request fields are captured here only; later changes are ignored.
          gnt_d        = w_pick;
          last_grant_d = w_pick;
          we_d         = w_we;
          sel_d        = w_sel;
          addr_d       = w_addr;
          wdata_d      = w_wdata;
          // The flash is read-only here: a write to it completes immediately
          // without touching the pins.
          if (w_we && !w_sel) begin
            state_d = c_done;
          end else begin
            state_d = c_cmd;
          end
        end
      end

      c_cmd: begin
        if (cnt_q == c_cmd_last) begin
          cnt_d   = 8'd0;
          state_d = c_addr;
        end
      end

      c_addr: begin
        if (cnt_q == c_addr_last) begin
          cnt_d = 8'd0;
          if (we_q || w_dummy_skip) begin
            state_d = c_data;
          end else begin
            state_d = c_dummy;
          end
        end
      end

      c_dummy: begin
        if (cnt_q == w_dummy_last) begin
          cnt_d   = 8'd0;
          state_d = c_data;
        end
      end

      c_data: begin
        // Read nibbles are taken on the edge that ends each phase B.
        if (!we_q && (cnt_q == 8'd1)) begin
          rd_hi_d = dq_in;
        end
        if (cnt_q == c_data_last) begin
          cnt_d   = 8'd0;
          state_d = c_done;
          if (!we_q) begin
            rdata_d = {rd_hi_q, dq_in};
          end
        end
      end

      c_done: begin
        cnt_d   = 8'd0;
        state_d = c_idle;
      end

      default: begin
        cnt_d   = 8'd0;
        state_d = c_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (decoded from the registered state and phase counter)
  // --------------------------------------------------------------------------
  always_comb begin
    ce0_n  = 1'b1;
    ce1_n  = 1'b1;
    sclk   = 1'b0;
    dq_out = 4'h0;
    dq_oe  = 4'h0;
    ack0   = 1'b0;
    ack1   = 1'b0;

    if (w_active) begin
      ce0_n = sel_q;
      ce1_n = ~sel_q;
      sclk  = cnt_q[0];                 // low in phase A, high in phase B
    end

    case (state_q)
      c_cmd: begin
        dq_oe  = 4'hF;
        dq_out = w_nib_idx[0] ? w_cmd[3:0] : w_cmd[7:4];
      end

      c_addr: begin
        dq_oe = 4'hF;
        case (w_nib_idx)
          3'd0:    dq_out = addr_q[23:20];
          3'd1:    dq_out = addr_q[19:16];
          3'd2:    dq_out = addr_q[15:12];
          3'd3:    dq_out = addr_q[11:8];
          3'd4:    dq_out = addr_q[7:4];
          default: dq_out = addr_q[3:0];
        endcase
      end

      c_data: begin
        if (we_q) begin
          dq_oe  = 4'hF;
          dq_out = w_nib_idx[0] ? wdata_q[3:0] : wdata_q[7:4];
        end
      end

      c_done: begin
        ack0 = ~gnt_q;
        ack1 = gnt_q;
      end

      default: begin
      end
    endcase
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != c_idle);

endmodule

`default_nettype wire

// File: tb/tb_lisa_qspi_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_lisa_qspi_arb
// Purpose  : Directed self-checking bench for lisa_qspi_arb. Each transaction
//            is traced cycle by cycle (cycle 0 = grant cycle) and the trace is
//            compared against hand-derived expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lisa_qspi_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, sel0, req1, we1, sel1;
  logic [23:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, busy, ce0_n, ce1_n, sclk;
  logic [7:0]  rdata;
  logic [3:0]  dq_out, dq_oe, dq_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle trace of the current transaction
  logic       tr_ce0  [0:255];
  logic       tr_ce1  [0:255];
  logic       tr_sclk [0:255];
  logic       tr_ack0 [0:255];
  logic       tr_ack1 [0:255];
  logic       tr_busy [0:255];
  logic [3:0] tr_dq   [0:255];
  logic [3:0] tr_oe   [0:255];
  logic [7:0] tr_rd   [0:255];

  lisa_qspi_arb dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .we0    (we0),
    .sel0   (sel0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .req1   (req1),
    .we1    (we1),
    .sel1   (sel1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .ack0   (ack0),
    .ack1   (ack1),
    .rdata  (rdata),
    .busy   (busy),
    .ce0_n  (ce0_n),
    .ce1_n  (ce1_n),
    .sclk   (sclk),
    .dq_out (dq_out),
    .dq_oe  (dq_oe),
    .dq_in  (dq_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int c);
    @(negedge clk);
    tr_ce0[c]  = ce0_n;
    tr_ce1[c]  = ce1_n;
    tr_sclk[c] = sclk;
    tr_ack0[c] = ack0;
    tr_ack1[c] = ack1;
    tr_busy[c] = busy;
    tr_dq[c]   = dq_out;
    tr_oe[c]   = dq_oe;
    tr_rd[c]   = rdata;
  endtask

  // One transaction from cycle 0 (request presented) through cycle ncyc.
  // The flash/PSRAM model returns nh in cycles 29-30 and nl in cycles 31-32.
  // rst_at > 0 pulses reset during that cycle.
  task automatic run_txn(input bit port, input bit we, input bit sel,
                         input logic [23:0] addr, input logic [7:0] wd,
                         input logic [3:0] nh, input logic [3:0] nl,
                         input int ncyc, input int rst_at);
    if (!port) begin
      req0 = 1'b1; we0 = we; sel0 = sel; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; sel1 = sel; addr1 = addr; wdata1 = wd;
    end
    dq_in = 4'h0;
    sample(0);
    tick();
    // Drop the request and scramble the fields: only grant-time values count.
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 24'hFFFFFF; addr1 = 24'hFFFFFF;
    wdata0 = ~wd; wdata1 = ~wd;
    we0 = ~we; we1 = ~we; sel0 = ~sel; sel1 = ~sel;
    for (int c = 1; c <= ncyc; c++) begin
      rst   = (c == rst_at);
      dq_in = (c == 29 || c == 30) ? nh : (c == 31 || c == 32) ? nl : 4'h0;
      sample(c);
      tick();
    end
    rst = 1'b0;
    we0 = 1'b0; we1 = 1'b0; sel0 = 1'b0; sel1 = 1'b0;
  endtask

  function automatic int ack_cycle(input bit port, input int n);
    for (int c = 1; c <= n; c++) begin
      if ((port ? tr_ack1[c] : tr_ack0[c]) === 1'b1) return c;
    end
    return 0;
  endfunction

  function automatic logic [63:0] nibs(input int first, input int n);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < n; i++) r = {r[59:0], tr_dq[first + 2 * i]};
    return r;
  endfunction

  // Chip enable low exactly in cycles lo..hi within 1..n (lo > hi: never low).
  function automatic bit ce_ok(input bit which, input int lo, input int hi, input int n);
    for (int c = 1; c <= n; c++) begin
      logic v = which ? tr_ce1[c] : tr_ce0[c];
      if (v !== ((c >= lo && c <= hi) ? 1'b0 : 1'b1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit oe_ok(input int last, input int n);
    for (int c = 1; c <= n; c++) begin
      if (tr_oe[c] !== ((c <= last) ? 4'hF : 4'h0)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit sclk_ok(input int last, input int n);
    for (int c = 1; c <= n; c++) begin
      if (tr_sclk[c] !== ((c <= last) ? ((c % 2) == 0) : 1'b0)) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    int n_ack;
    int ack_port [0:7];
    int ack_cyc  [0:7];
    int run, min_gap;
    bit seen_low, both_ack, both_ce;
    int waited;

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; sel0 = 1'b0; addr0 = 24'd0; wdata0 = 8'd0;
    req1 = 1'b0; we1 = 1'b0; sel1 = 1'b0; addr1 = 24'd0; wdata1 = 8'd0;
    dq_in = 4'h0;

    // ---------------- reset with live requests ----------------
    tick();
    req0 = 1'b1;
    req1 = 1'($urandom_range(0, 1));
    sel0 = 1'b1;
    @(negedge clk);
    check("rst_pins_c1", 64'({ce0_n, ce1_n, sclk, dq_out, dq_oe, ack0, ack1, busy}),
          64'({1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}));
    check("rst_rdata", 64'(rdata), 64'h00);
    tick();
    @(negedge clk);
    check("rst_pins_c2", 64'({ce0_n, ce1_n, sclk, dq_out, dq_oe, ack0, ack1, busy}),
          64'({1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}));
    tick();
    req0 = 1'b0; req1 = 1'b0; sel0 = 1'b0; rst = 1'b0;
    tick();

    // ---------------- PSRAM read, port 1 ----------------
    run_txn(1'b1, 1'b0, 1'b1, 24'h000100, 8'h00, 4'hA, 4'h5, 34, 0);
    check("rd_nibbles", nibs(1, 8), 64'hEB000100);
    check("rd_ce1", 64'(ce_ok(1'b1, 1, 32, 34)), 64'd1);
    check("rd_ce0", 64'(ce_ok(1'b0, 1, 0, 34)), 64'd1);
    check("rd_oe", 64'(oe_ok(16, 34)), 64'd1);
    check("rd_sclk", 64'(sclk_ok(32, 34)), 64'd1);
    check("rd_ack1_cycle", 64'(ack_cycle(1'b1, 34)), 64'd33);
    check("rd_ack0_none", 64'(ack_cycle(1'b0, 34)), 64'd0);
    check("rd_rdata", 64'(tr_rd[33]), 64'hA5);
    check("rd_idle_after", 64'(tr_busy[34]), 64'd0);

    // ---------------- PSRAM write, port 0 ----------------
    run_txn(1'b0, 1'b1, 1'b1, 24'h012345, 8'h3C, 4'h0, 4'h0, 22, 0);
    check("wr_nibbles", nibs(1, 10), 64'h380123453C);
    check("wr_ce1", 64'(ce_ok(1'b1, 1, 20, 22)), 64'd1);
    check("wr_oe", 64'(oe_ok(20, 22)), 64'd1);
    check("wr_ack0_cycle", 64'(ack_cycle(1'b0, 22)), 64'd21);
    check("wr_ack1_none", 64'(ack_cycle(1'b1, 22)), 64'd0);
    check("wr_rdata_kept", 64'({tr_rd[21], tr_rd[22]}), 64'hA5A5);

    // ---------------- flash write rejection ----------------
    run_txn(1'b0, 1'b1, 1'b0, 24'h000010, 8'hFF, 4'h0, 4'h0, 3, 0);
    check("fw_ack0_cycle", 64'(ack_cycle(1'b0, 3)), 64'd1);
    check("fw_ce0_high", 64'(ce_ok(1'b0, 1, 0, 3)), 64'd1);
    check("fw_ce1_high", 64'(ce_ok(1'b1, 1, 0, 3)), 64'd1);
    check("fw_sclk_low", 64'(sclk_ok(0, 3)), 64'd1);
    check("fw_rdata_kept", 64'(tr_rd[1]), 64'hA5);

    // ---------------- reset during ADDR ----------------
    run_txn(1'b1, 1'b0, 1'b1, 24'h000200, 8'h00, 4'h0, 4'h0, 14, 10);
    check("mr_ce1", 64'(ce_ok(1'b1, 1, 10, 14)), 64'd1);
    check("mr_sclk", 64'(sclk_ok(10, 14)), 64'd1);
    check("mr_oe", 64'(oe_ok(10, 14)), 64'd1);
    check("mr_busy_c11", 64'(tr_busy[11]), 64'd0);
    check("mr_no_ack", 64'(ack_cycle(1'b1, 14) + ack_cycle(1'b0, 14)), 64'd0);
    check("mr_rdata_cleared", 64'(tr_rd[11]), 64'h00);
    run_txn(1'b1, 1'b0, 1'b1, 24'h000100, 8'h00, 4'h6, 4'h9, 34, 0);
    check("mr_read_ack1", 64'(ack_cycle(1'b1, 34)), 64'd33);
    check("mr_read_rdata", 64'(tr_rd[33]), 64'h69);
    check("mr_read_nibbles", nibs(1, 8), 64'hEB000100);

    // ---------------- contention: both held high ----------------
    // Port 0 writes PSRAM (ack 21 cycles after grant), port 1 reads PSRAM
    // (ack 33 cycles after grant); each grant follows the IDLE cycle after DONE.
    req0 = 1'b1; we0 = 1'b1; sel0 = 1'b1; addr0 = 24'h000ABC; wdata0 = 8'h5A;
    req1 = 1'b1; we1 = 1'b0; sel1 = 1'b1; addr1 = 24'h000DEF; wdata1 = 8'h00;
    dq_in = 4'h7;
    n_ack = 0; both_ack = 1'b0; both_ce = 1'b0;
    for (int c = 0; c <= 115; c++) begin
      sample(c);
      if (tr_ack0[c] === 1'b1 && n_ack < 8) begin ack_port[n_ack] = 0; ack_cyc[n_ack] = c; n_ack++; end
      if (tr_ack1[c] === 1'b1 && n_ack < 8) begin ack_port[n_ack] = 1; ack_cyc[n_ack] = c; n_ack++; end
      if (tr_ack0[c] === 1'b1 && tr_ack1[c] === 1'b1) both_ack = 1'b1;
      if (tr_ce0[c] === 1'b0 && tr_ce1[c] === 1'b0) both_ce = 1'b1;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    check("ct_ack_count", 64'(n_ack), 64'd4);
    for (int i = 0; i < 8; i++) begin
      if (i >= n_ack) begin ack_port[i] = -1; ack_cyc[i] = -1; end
    end
    check("ct_ack_a", 64'({ack_port[0][7:0], ack_cyc[0][15:0]}), 64'h00_0015);
    check("ct_ack_b", 64'({ack_port[1][7:0], ack_cyc[1][15:0]}), 64'h01_0037);
    check("ct_ack_c", 64'({ack_port[2][7:0], ack_cyc[2][15:0]}), 64'h00_004D);
    check("ct_ack_d", 64'({ack_port[3][7:0], ack_cyc[3][15:0]}), 64'h01_006F);
    check("ct_excl", 64'({both_ack, both_ce}), 64'd0);
    check("ct_rdata", 64'(tr_rd[111]), 64'h77);
    run = 0; min_gap = 1000; seen_low = 1'b0;
    for (int c = 1; c <= 115; c++) begin
      if (tr_ce1[c] === 1'b1) begin
        run++;
      end else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        run = 0;
        seen_low = 1'b1;
      end
    end
    check("ct_ce_gap", 64'(min_gap), 64'd2);

    // Drain the transaction granted at cycle 112 (bounded wait).
    waited = 0;
    @(negedge clk);
    while (busy !== 1'b0 && waited < 60) begin
      tick();
      @(negedge clk);
      waited++;
    end
    check("ct_drain_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lisa_qspi_arb.md
Name: lisa_qspi_arb

Overview:
- Shares the single QSPI pin set (sclk, dq[3:0]) between the SPI flash (CE0) and the SPI PSRAM (CE1).
- Serves two requesters: port 0 is instruction fetch, port 1 is data load/store.
- Uses round-robin arbitration and sequences one complete quad-mode single-byte transaction per grant: command, 24-bit address, dummy cycles for reads, then data.
- Sits between the core/cache logic and the uio pads; both devices are already in QPI mode when this block runs.

Parameters:
- DUMMY_FLASH, 6, dummy sclk cycles for flash reads.
- DUMMY_PSRAM, 6, dummy sclk cycles for PSRAM reads.
- CMD_RD, 8'hEB, read command byte.
- CMD_WR, 8'h38, write command byte (PSRAM only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- req0/req1  in  1  transaction request, ports 0/1.
- we0/we1  in  1  1 = write, 0 = read.
- sel0/sel1  in  1  target: 0 = flash (CE0), 1 = PSRAM (CE1).
- addr0/addr1  in  24  byte address.
- wdata0/wdata1  in  8  write data.
- ack0/ack1  out  1  one-cycle completion pulse.
- rdata  out  8  read data, shared by both ports.
- busy  out  1  transaction in progress (state != IDLE).
- ce0_n, ce1_n  out  1  flash / PSRAM chip enables.
- sclk  out  1  QSPI clock.
- dq_out  out  4  QSPI data out.
- dq_oe  out  4  per-bit output enable.
- dq_in  in  4  QSPI data in.

Behaviour:
- Reset values: ce0_n=ce1_n=1, sclk=0, dq_out=0, dq_oe=0, ack0=ack1=0, rdata=0, busy=0, state=IDLE, last_grant=1 (so port 0 wins first).
- A reset asserted mid-transaction aborts it on that edge. No ack is issued and the pins take their reset values the next cycle.
- States: IDLE, CMD, ADDR, DUMMY, DATA, DONE.
- Arbitration in IDLE only:
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_grant.
  - On grant, latch we, sel, addr and wdata into internal registers and update last_grant.
- Timing, with the grant edge at the end of cycle 0:
  - The selected ce_n goes low in cycle 1 and stays low through DATA.
  - Each nibble slot is 2 clk: phase A sclk=0 with dq_out driving the new nibble, then phase B sclk=1.
  - Nibble order is MSB first.
  - Reads capture dq_in on the edge that ends phase B.
- Phase lengths:
  - CMD: 2 nibbles, cycles 1-4.
  - ADDR: 6 nibbles, cycles 5-16.
  - DUMMY (reads only): 2*DUMMY_x clk with dq_oe=0 and sclk still toggling.
  - DATA: 2 nibbles. Writes drive wdata with dq_oe=4'hF; reads use dq_oe=0 and assemble the high nibble, then the low nibble.
- dq_oe=4'hF during CMD and ADDR.
- DONE lasts 1 cycle: ce_n=1, sclk=0, dq_oe=0, ackN=1 for the granted port, and rdata updated on reads.
  - rdata holds until the next read completes; writes leave it unchanged.
- Latency with default parameters:
  - Read: ack in cycle 33.
  - Write: ack in cycle 21.
- Flash write (we=1, sel=0) is rejected: no pin activity, ce stays high, state goes IDLE→DONE, ack in cycle 1.
- After DONE the block returns to IDLE, so ce_n is high for at least 2 cycles between transactions.
- Request protocol:
  - req, we, sel, addr and wdata are sampled only at grant, so changes afterwards are ignored.
  - Dropping req mid-transaction does not abort it; ack still pulses.
  - req high in the cycle after ack counts as a new request; the requester presents its new address on the ack edge.
- Only one of ack0/ack1 is ever high; ce0_n and ce1_n are never both low.

Test Plan:
- Reset: hold rst 2 cycles with random req → all outputs at reset values, no ce activity until rst low.
- PSRAM read: port 1, addr 24'h000100; model drives 4'hA then 4'h5 during DATA → dq_out sequence E,B,0,0,0,1,0,0; dq_oe=0 from cycle 17; ack1 in cycle 33; rdata=8'hA5.
- PSRAM write: port 0, addr 24'h012345, wdata 8'h3C → ce1_n low cycles 1-20; nibbles 3,8,0,1,2,3,4,5,3,C; ack0 in cycle 21; rdata unchanged.
- Contention: req0 and req1 both high in the same cycle, both held high → grants alternate 0,1,0,1; each ack matches its grant; ce_n high ≥2 cycles between transactions.
- Flash write rejection: we0=1, sel0=0 → ce0_n and ce1_n stay 1, sclk stays 0, ack0 in cycle 1.
- Mid-transaction reset: assert rst during ADDR (cycle 10) → ce_n=1, sclk=0, dq_oe=0 on the next cycle, no ack; a new read after reset completes normally with ack at cycle 33.
